// File: rtl/redirect_ctl.sv
// Front-end redirect sequencer: arbitrates trap > branch/jump > fence.i,
// holds the winning target until fetch accepts it, then masks wrong-path requests.
module redirect_ctl #(
   parameter int XLEN       = 64,
   parameter int SHADOW_CYC = 2,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bj_en,
   input  logic [XLEN-1:0]  bj_pc,
   input  logic             trap_en,
   input  logic [XLEN-1:0]  trap_pc,
   input  logic             fencei_en,
   input  logic [XLEN-1:0]  fencei_pc,
   input  logic             if_ready,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush_if,
   output logic             flush_id,
   output logic             busy,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam int SH_W = (SHADOW_CYC < 1) ? 1 : $clog2(SHADOW_CYC + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      SHADOW = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              flush_q, flush_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SH_W-1:0]   shadow_q, shadow_d;

   // Next-state and next-output computation for the redirect sequencer.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      pc_d     = pc_q;
      flush_d  = 1'b0;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      case (state_q)
         IDLE: begin
            if (trap_en) begin
               state_d = PEND;
               valid_d = 1'b1;
               pc_d    = trap_pc;
               flush_d = 1'b1;
            end else if (bj_en) begin
               state_d = PEND;
               valid_d = 1'b1;
               pc_d    = bj_pc;
               flush_d = 1'b1;
            end else if (fencei_en) begin
               state_d = PEND;
               valid_d = 1'b1;
               pc_d    = fencei_pc;
               flush_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         PEND: begin
            // A trap overrides the pending target even if fetch is ready this cycle.
            if (trap_en) begin
               pc_d    = trap_pc;
               flush_d = 1'b1;
            end else if (if_ready) begin
               valid_d  = 1'b0;
               cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               shadow_d = SH_W'(SHADOW_CYC);
               state_d  = (SHADOW_CYC == 0) ? IDLE : SHADOW;
            end else begin
               state_d = PEND;
            end
         end
         SHADOW: begin
            if (trap_en) begin
               state_d  = PEND;
               valid_d  = 1'b1;
               pc_d     = trap_pc;
               flush_d  = 1'b1;
               shadow_d = {SH_W{1'b0}};
            end else if (shadow_q <= {{(SH_W-1){1'b0}}, 1'b1}) begin
               state_d  = IDLE;
               shadow_d = {SH_W{1'b0}};
            end else begin
               shadow_d = shadow_q - {{(SH_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            shadow_d = {SH_W{1'b0}};
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         valid_q  <= 1'b0;
         pc_q     <= {XLEN{1'b0}};
         flush_q  <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         shadow_q <= {SH_W{1'b0}};
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         flush_q  <= flush_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   assign redirect_valid = valid_q;
   assign redirect_pc    = pc_q;
   assign flush_if       = flush_q;
   assign flush_id       = flush_q;
   assign busy           = busy_q;
   assign redirect_cnt   = cnt_q;

endmodule

// File: tb/tb_redirect_ctl.sv
// Directed bench for redirect_ctl: default instance plus a SHADOW_CYC=0, CNT_W=4 instance.
module tb_redirect_ctl;

   logic        clk;
   logic        rst_n;
   logic        bj_en, trap_en, fencei_en, if_ready;
   logic [63:0] bj_pc, trap_pc, fencei_pc;

   logic        rv, fif, fid, bsy;
   logic [63:0] rpc;
   logic [31:0] cnt;

   logic        rv2, fif2, fid2, bsy2;
   logic [63:0] rpc2;
   logic [3:0]  cnt2;

   int errors;
   int checks;

   redirect_ctl #(.XLEN(64), .SHADOW_CYC(2), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .bj_en(bj_en), .bj_pc(bj_pc),
      .trap_en(trap_en), .trap_pc(trap_pc),
      .fencei_en(fencei_en), .fencei_pc(fencei_pc),
      .if_ready(if_ready),
      .redirect_valid(rv), .redirect_pc(rpc),
      .flush_if(fif), .flush_id(fid),
      .busy(bsy), .redirect_cnt(cnt)
   );

   redirect_ctl #(.XLEN(64), .SHADOW_CYC(0), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .bj_en(bj_en), .bj_pc(bj_pc),
      .trap_en(trap_en), .trap_pc(trap_pc),
      .fencei_en(fencei_en), .fencei_pc(fencei_pc),
      .if_ready(if_ready),
      .redirect_valid(rv2), .redirect_pc(rpc2),
      .flush_if(fif2), .flush_id(fid2),
      .busy(bsy2), .redirect_cnt(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bj_en = 1'b0; trap_en = 1'b0; fencei_en = 1'b0; if_ready = 1'b0;
      bj_pc = 64'h0; trap_pc = 64'h0; fencei_pc = 64'h0;
      #23;
      chk("rst_valid", {63'd0, rv}, 64'd0);
      chk("rst_pc", rpc, 64'd0);
      chk("rst_busy", {63'd0, bsy}, 64'd0);
      chk("rst_cnt", {32'd0, cnt}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Single branch
      bj_en = 1'b1; bj_pc = 64'h8000_0100; if_ready = 1'b1;
      tick();
      bj_en = 1'b0;
      chk("br_valid", {63'd0, rv}, 64'd1);
      chk("br_pc", rpc, 64'h8000_0100);
      chk("br_flush_if", {63'd0, fif}, 64'd1);
      chk("br_flush_id", {63'd0, fid}, 64'd1);
      chk("br_busy", {63'd0, bsy}, 64'd1);
      tick();
      chk("br_acc_valid", {63'd0, rv}, 64'd0);
      chk("br_cnt", {32'd0, cnt}, 64'd1);
      chk("br_shadow1", {63'd0, bsy}, 64'd1);
      chk("br_flush_clr", {63'd0, fif}, 64'd0);
      tick();
      chk("br_shadow2", {63'd0, bsy}, 64'd1);
      tick();
      chk("br_idle", {63'd0, bsy}, 64'd0);

      // Priority: trap beats bj and fence.i
      trap_en = 1'b1; trap_pc = 64'h8000_0004;
      bj_en = 1'b1; bj_pc = 64'h8000_0200;
      fencei_en = 1'b1; fencei_pc = 64'h8000_0300;
      tick();
      trap_en = 1'b0; bj_en = 1'b0; fencei_en = 1'b0;
      chk("pri_pc", rpc, 64'h8000_0004);
      tick();
      chk("pri_cnt", {32'd0, cnt}, 64'd2);
      tick();
      tick();
      chk("pri_idle", {63'd0, bsy}, 64'd0);

      // Stalled fetch: valid held five cycles, one flush, one count
      if_ready = 1'b0;
      bj_en = 1'b1; bj_pc = 64'h8000_0300;
      tick();
      bj_en = 1'b0;
      chk("stall_flush_first", {63'd0, fif}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", {63'd0, rv}, 64'd1);
         chk("stall_pc", rpc, 64'h8000_0300);
         chk("stall_flush_off", {63'd0, fid}, 64'd0);
      end
      tick();
      chk("stall_valid5", {63'd0, rv}, 64'd1);
      chk("stall_cnt_hold", {32'd0, cnt}, 64'd2);
      if_ready = 1'b1;
      tick();
      chk("stall_acc", {63'd0, rv}, 64'd0);
      chk("stall_cnt", {32'd0, cnt}, 64'd3);
      tick();
      tick();

      // Override in PEND by trap (with if_ready high, no handshake counted)
      if_ready = 1'b0;
      bj_en = 1'b1; bj_pc = 64'h0000_0100;
      tick();
      bj_en = 1'b0;
      chk("ovr_bj_pc", rpc, 64'h100);
      tick();
      chk("ovr_flush_gap", {63'd0, fif}, 64'd0);
      trap_en = 1'b1; trap_pc = 64'h8000_0004; if_ready = 1'b1;
      tick();
      trap_en = 1'b0;
      chk("ovr_pc", rpc, 64'h8000_0004);
      chk("ovr_flush2", {63'd0, fif}, 64'd1);
      chk("ovr_valid", {63'd0, rv}, 64'd1);
      chk("ovr_cnt_hold", {32'd0, cnt}, 64'd3);
      tick();
      chk("ovr_acc", {63'd0, rv}, 64'd0);
      chk("ovr_cnt", {32'd0, cnt}, 64'd4);

      // Shadow masking of bj across both shadow cycles
      bj_en = 1'b1; bj_pc = 64'h8000_0200;
      tick();
      chk("sh_mask1", {63'd0, rv}, 64'd0);
      tick();
      bj_en = 1'b0;
      chk("sh_mask2", {63'd0, rv}, 64'd0);
      chk("sh_idle", {63'd0, bsy}, 64'd0);
      chk("sh_cnt", {32'd0, cnt}, 64'd4);

      // Trap taken during shadow
      bj_en = 1'b1; bj_pc = 64'h8000_0600;
      tick();
      bj_en = 1'b0;
      tick();
      chk("sh_cnt5", {32'd0, cnt}, 64'd5);
      trap_en = 1'b1; trap_pc = 64'h8000_0008;
      tick();
      trap_en = 1'b0;
      chk("sh_trap_valid", {63'd0, rv}, 64'd1);
      chk("sh_trap_pc", rpc, 64'h8000_0008);
      chk("sh_trap_flush", {63'd0, fif}, 64'd1);
      tick();
      chk("sh_trap_cnt", {32'd0, cnt}, 64'd6);
      tick();
      tick();

      // Asynchronous reset while pending
      if_ready = 1'b0;
      bj_en = 1'b1; bj_pc = 64'h8000_0400;
      tick();
      bj_en = 1'b0;
      chk("rp_valid", {63'd0, rv}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rp_valid0", {63'd0, rv}, 64'd0);
      chk("rp_pc0", rpc, 64'd0);
      chk("rp_flush0", {62'd0, fif, fid}, 64'd0);
      chk("rp_busy0", {63'd0, bsy}, 64'd0);
      chk("rp_cnt0", {32'd0, cnt}, 64'd0);
      #3;
      rst_n = 1'b1;
      tick();
      bj_en = 1'b1; bj_pc = 64'h8000_0500; if_ready = 1'b1;
      tick();
      bj_en = 1'b0;
      chk("rp_post_valid", {63'd0, rv}, 64'd1);
      chk("rp_post_pc", rpc, 64'h8000_0500);
      tick();
      chk("rp_post_cnt", {32'd0, cnt}, 64'd1);

      // SHADOW_CYC=0 instance: idle right after handshake, counter wraps at 16
      chk("z_idle", {63'd0, bsy2}, 64'd0);
      chk("z_cnt1", {60'd0, cnt2}, 64'd1);
      for (int i = 0; i < 14; i++) begin
         bj_en = 1'b1; bj_pc = 64'h8000_1000 + 64'(i);
         tick();
         bj_en = 1'b0;
         tick();
      end
      chk("z_cnt15", {60'd0, cnt2}, 64'd15);
      bj_en = 1'b1; bj_pc = 64'h8000_2000;
      tick();
      bj_en = 1'b0;
      chk("z_pc", rpc2, 64'h8000_2000);
      tick();
      chk("z_wrap", {60'd0, cnt2}, 64'd0);
      chk("z_wrap_idle", {63'd0, bsy2}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/redirect_ctl.md
Name: redirect_ctl

Overview:
- Sequences front-end redirects for the core and arbitrates between three redirect sources: trap/interrupt entry, branch/jump resolution from execute, and fence.i refetch.
- Registers the winning target and holds it with a valid/ready handshake until fetch accepts it.
- Pulses flushes to the IF and ID stages.
- Masks younger wrong-path branch/fence.i requests for a programmable shadow window after each accepted redirect.
- Sits between the execute stage, the trap unit and the fetch PC mux.

Parameters:
- XLEN, 64, datapath/PC width.
- SHADOW_CYC, 2, cycles after redirect acceptance during which bj/fence.i requests are ignored (0 allowed).
- CNT_W, 32, width of the redirect performance counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- bj_en  input  1  branch taken / jump from execute
- bj_pc  input  XLEN  branch/jump target
- trap_en  input  1  trap or interrupt entry request
- trap_pc  input  XLEN  trap vector target
- fencei_en  input  1  fence.i refetch request
- fencei_pc  input  XLEN  refetch PC (pc+4 of fence.i)
- if_ready  input  1  fetch accepts redirect this cycle
- redirect_valid  output  1  redirect target presented to fetch
- redirect_pc  output  XLEN  registered redirect target
- flush_if  output  1  one-cycle kill of IF stage contents
- flush_id  output  1  one-cycle kill of ID stage contents
- busy  output  1  state != IDLE
- redirect_cnt  output  CNT_W  count of accepted redirects

Behaviour:
- Reset (rst_n low, any time, including mid-handshake):
  - state=IDLE; redirect_valid=0, redirect_pc=0, flush_if=0, flush_id=0, busy=0, redirect_cnt=0; shadow counter=0.
- Arbitration, same-cycle priority: trap > bj > fencei. Losers are dropped, not queued.
- States: IDLE, PEND, SHADOW.
- IDLE:
  - Any enabled request in cycle N → cycle N+1: state=PEND, redirect_valid=1, redirect_pc=winner target.
  - flush_if and flush_id are 1 for cycle N+1 only.
  - Latency from request to redirect_valid is exactly 1 cycle.
- PEND:
  - redirect_valid held at 1 and redirect_pc stable until a cycle with if_ready=1. That cycle is the handshake.
  - Handshake → next cycle: redirect_valid=0, redirect_cnt+1 (wraps at 2^CNT_W).
  - After handshake: state=SHADOW with counter=SHADOW_CYC, or IDLE if SHADOW_CYC=0.
  - trap_en in PEND, whether or not if_ready is high that cycle: replaces redirect_pc with trap_pc next cycle, stays in PEND, re-pulses flush_if/flush_id for one cycle. No handshake is counted that cycle.
  - bj_en/fencei_en in PEND are ignored (younger, wrong-path).
- SHADOW:
  - Counter decrements each cycle; at the cycle it reads 1, next state=IDLE.
  - bj_en/fencei_en are ignored.
  - trap_en is accepted exactly as in IDLE (→PEND next cycle, flush pulse). The shadow count is abandoned.
- Requests while stalled: fetch stall is expressed only through if_ready. Requests are never lost due to a stall once latched.
- busy = (state != IDLE). It is the registered state, so it is high from cycle N+1 of the first request.
- Widths: all targets are XLEN bits and passed unmodified. Bit 0 masking is the source's responsibility.
- No combinational path exists from any input to any output; all outputs are registered.

Test Plan:
- Single branch: bj_en=1, bj_pc=0x8000_0100 at cycle 5, if_ready=1 → cycle 6: redirect_valid=1, pc=0x8000_0100, flush_if=flush_id=1. Cycle 7: redirect_valid=0, redirect_cnt=1, state SHADOW. Cycles 7–8 SHADOW; IDLE at cycle 9.
- Priority: trap_en (0x8000_0004), bj_en (0x8000_0200) and fencei_en same cycle → redirect_pc=0x8000_0004 only. redirect_cnt increments by exactly 1.
- Stalled fetch: bj_en with if_ready=0 for 4 cycles then 1 → redirect_valid high 5 cycles, pc stable, flush pulses only in the first cycle, redirect_cnt+1 once.
- Override in PEND: bj to 0x100 pending with if_ready=0, then trap_en to 0x8000_0004 → next cycle redirect_pc=0x8000_0004 with a second flush pulse. The accepted target is the trap vector.
- Shadow masking: bj_en asserted on both SHADOW cycles after acceptance → no redirect_valid, count unchanged. trap_en during SHADOW → redirect next cycle.
- Reset mid-PEND: rst_n low asynchronously while redirect_valid=1 → all outputs 0 immediately. After release, a bj request redirects normally. Also cover SHADOW_CYC=0: IDLE directly after handshake, and redirect_cnt wrap at CNT_W=4 after 16 redirects.
